// File: rtl/whack_pkg.sv
// whack_pkg: shared game constants and BCD converter state encoding
package whack_pkg;
    localparam int BCD_DIGIT_W  = 4;
    localparam int BCD_MAX      = 9;
    localparam int SCORE_DIGITS = 3;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FINISH} state_t;
endpackage

// File: rtl/bcd_to_score_if.sv
// bcd_to_score_if: start/busy/done conversion bus for the BCD-to-score converter
interface bcd_to_score_if #(parameter int NDIG = 3, parameter int OUT_W = 8);
    logic start;
    logic [4*NDIG-1:0] bcd_in;
    logic busy;
    logic done;
    logic [OUT_W-1:0] score;
    logic err;
    logic ovf;
    modport master (output start, bcd_in, input busy, done, score, err, ovf);
    modport slave (input start, bcd_in, output busy, done, score, err, ovf);
endinterface

// File: rtl/bcd_digit_corr.sv
// bcd_digit_corr: reverse double-dabble digit correction (subtract 3 when >= 8)
module bcd_digit_corr
    import whack_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);
    assign dout = din >= BCD_DIGIT_W'(8) ? din - BCD_DIGIT_W'(3) : din;
endmodule

// File: rtl/bcd_to_score.sv
// bcd_to_score: multi-cycle packed-BCD to binary score converter (shift-right / subtract-3).
// BCD_TO_SCORE_SAT_EN: saturate score to all ones on overflow instead of truncating.
module bcd_to_score
    import whack_pkg::*;
#(
    parameter int NDIG  = SCORE_DIGITS,
    parameter int OUT_W = 8
) (
    input logic clk,
    input logic reset,
    bcd_to_score_if.slave bus
);
    localparam int W  = BCD_DIGIT_W * NDIG;
    localparam int CW = $clog2(W + 1);
    state_t state, nstate;
    logic [W-1:0] bcd_reg, bin_reg, sh_bcd, cor_bcd;
    logic [CW-1:0] cnt;
    logic [NDIG-1:0] bad_d;
    logic [OUT_W-1:0] res;
    logic bad, errf, ovf_c;
    assign sh_bcd = bcd_reg >> 1;
    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        bcd_digit_corr u_corr (
            .din (sh_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .dout(cor_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
        assign bad_d[i] = bus.bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX);
    end
    assign bad = |bad_d;
    assign ovf_c = |bin_reg[W-1:OUT_W];
`ifdef BCD_TO_SCORE_SAT_EN
    assign res = ovf_c ? '1 : bin_reg[OUT_W-1:0];
`else
    assign res = bin_reg[OUT_W-1:0];
`endif
    assign bus.busy = state != ST_IDLE;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ST_IDLE;
        else state <= nstate;
    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:   nstate = bus.start ? (bad ? ST_FINISH : ST_SHIFT) : ST_IDLE;
            ST_SHIFT:  nstate = cnt == CW'(1) ? ST_FINISH : ST_SHIFT;
            default:   nstate = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_reg   <= '0;
            bin_reg   <= '0;
            cnt       <= '0;
            errf      <= 1'b0;
            bus.done  <= 1'b0;
            bus.score <= '0;
            bus.err   <= 1'b0;
            bus.ovf   <= 1'b0;
        end else begin
            bus.done <= state == ST_FINISH;
            if (state == ST_IDLE && bus.start) begin
                bcd_reg <= bus.bcd_in;
                bin_reg <= '0;
                cnt     <= bad ? '0 : CW'(W);
                errf    <= bad;
            end
            if (state == ST_SHIFT) begin
                bcd_reg <= cor_bcd;
                bin_reg <= {bcd_reg[0], bin_reg[W-1:1]};
                cnt     <= cnt - CW'(1);
            end
            if (state == ST_FINISH) begin
                bus.err <= errf;
                bus.ovf <= ovf_c;
                if (!errf) bus.score <= res;
            end
        end
    end
endmodule

// File: tb/tb_bcd_to_score.sv
// tb_bcd_to_score: directed table-driven check of the BCD-to-score converter
module tb_bcd_to_score;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    bcd_to_score_if #(.NDIG(3), .OUT_W(8)) bus ();
    bcd_to_score #(.NDIG(3), .OUT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
`ifdef BCD_TO_SCORE_SAT_EN
    localparam logic [7:0] S256 = 8'hFF, S999 = 8'hFF, S909 = 8'hFF;
`else
    localparam logic [7:0] S256 = 8'h00, S999 = 8'hE7, S909 = 8'h8D;
`endif
    typedef struct {
        logic [11:0] bcd;
        logic [7:0]  score;
        logic        err;
        logic        ovf;
    } vec_t;
    vec_t vecs[10];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic conv(input logic [11:0] bcd, output int lat, output int busy_n);
        bus.bcd_in = bcd;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        busy_n = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy && !bus.done) busy_n++;
        end
    endtask
    initial begin
        int lat, busy_n, dones;
        vecs[0] = '{12'h000, 8'd0,   1'b0, 1'b0};
        vecs[1] = '{12'h042, 8'd42,  1'b0, 1'b0};
        vecs[2] = '{12'h1A0, 8'd42,  1'b1, 1'b0};
        vecs[3] = '{12'h255, 8'd255, 1'b0, 1'b0};
        vecs[4] = '{12'h256, S256,   1'b0, 1'b1};
        vecs[5] = '{12'h999, S999,   1'b0, 1'b1};
        vecs[6] = '{12'h0F0, S999,   1'b1, 1'b0};
        vecs[7] = '{12'h909, S909,   1'b0, 1'b1};
        vecs[8] = '{12'h099, 8'd99,  1'b0, 1'b0};
        vecs[9] = '{12'h128, 8'd128, 1'b0, 1'b0};
        bus.start = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_score", 32'(bus.score), 0);
        chk("reset_err_ovf", {bus.err, bus.ovf}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            conv(vecs[k].bcd, lat, busy_n);
            chk($sformatf("lat_%03h", vecs[k].bcd), 32'(lat), vecs[k].err ? 1 : 13);
            chk($sformatf("busy_%03h", vecs[k].bcd), 32'(busy_n), vecs[k].err ? 1 : 13);
            chk($sformatf("score_%03h", vecs[k].bcd), 32'(bus.score), 32'(vecs[k].score));
            chk($sformatf("err_%03h", vecs[k].bcd), 32'(bus.err), 32'(vecs[k].err));
            if (!vecs[k].err) chk($sformatf("ovf_%03h", vecs[k].bcd), 32'(bus.ovf), 32'(vecs[k].ovf));
            @(posedge clk); #1;
            chk($sformatf("pulse_%03h", vecs[k].bcd), 32'(bus.done), 0);
        end
        // start re-pulsed mid-conversion with a new operand must be ignored
        bus.bcd_in = 12'h123;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0;
        for (int c = 1; c < 30; c++) begin
            if (c == 3 || c == 7) begin
                bus.start = 1'b1;
                bus.bcd_in = 12'h045;
            end else bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("repulse_dones", 32'(dones), 1);
        chk("repulse_score", 32'(bus.score), 123);
        // reset mid-conversion aborts with no done
        bus.bcd_in = 12'h077;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_score", 32'(bus.score), 0);
        chk("abort_err_ovf", {bus.err, bus.ovf}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("abort_no_done", 32'(dones), 0);
        conv(12'h100, lat, busy_n);
        chk("after_abort_lat", 32'(lat), 13);
        chk("after_abort_score", 32'(bus.score), 100);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
